// File: rtl/groestl_arbiter.sv
// Two-port round-robin arbiter sharing one Groestl core interface between two hosts.
// A requester holds the core until it drops req; an idle timeout reclaims a stalled owner.
module groestl_arbiter #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0,
  input  logic        req1,
  input  logic        load0,
  input  logic        load1,
  input  logic        fetch0,
  input  logic        fetch1,
  output logic        gnt0,
  output logic        gnt1,
  output logic        ack0,
  output logic        ack1,
  output logic [15:0] odata0,
  output logic [15:0] odata1,
  output logic        timeout,
  output logic        core_load,
  output logic        core_fetch,
  input  logic        core_busy,
  input  logic        core_ack,
  input  logic [15:0] core_odata
);

  localparam int unsigned CNT_W  = 8;
  localparam int unsigned DATA_W = 16;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  // Compared only when the timeout is enabled, so the wrap at TIMEOUT=0 is harmless.
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);
  localparam bit               TO_EN   = (TIMEOUT != 0);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_OWN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  logic [1:0]       state_q, state_d;
  logic             owner_q, owner_d;
  logic             last_q, last_d;
  logic [CNT_W-1:0] idle_cnt_q, idle_cnt_d;
  logic             gnt0_q, gnt0_d;
  logic             gnt1_q, gnt1_d;
  logic             timeout_q, timeout_d;

  logic             cyc_idle_c;
  logic             req_own_c;
  logic             to_hit_c;
  logic             winner_c;

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      owner_q    <= 1'b0;
      last_q     <= 1'b1;
      idle_cnt_q <= '0;
      gnt0_q     <= 1'b0;
      gnt1_q     <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      last_q     <= last_d;
      idle_cnt_q <= idle_cnt_d;
      gnt0_q     <= gnt0_d;
      gnt1_q     <= gnt1_d;
      timeout_q  <= timeout_d;
    end
  end

  assign gnt0    = gnt0_q;
  assign gnt1    = gnt1_q;
  assign timeout = timeout_q;

  // Core strobe muxing and ack/odata return routing (zero added latency)
  always_comb begin
    core_load  = 1'b0;
    core_fetch = 1'b0;
    ack0       = 1'b0;
    ack1       = 1'b0;
    odata0     = DATA_W'(0);
    odata1     = DATA_W'(0);
    if (state_q == ST_OWN) begin
      core_load  = owner_q ? load1  : load0;
      core_fetch = owner_q ? fetch1 : fetch0;
    end
    if ((state_q == ST_OWN) || (state_q == ST_DRAIN)) begin
      if (owner_q) begin
        ack1   = core_ack;
        odata1 = core_odata;
      end else begin
        ack0   = core_ack;
        odata0 = core_odata;
      end
    end
  end

  assign cyc_idle_c = ~(core_load | core_fetch | core_busy | core_ack);
  assign req_own_c  = owner_q ? req1 : req0;
  assign to_hit_c   = TO_EN && cyc_idle_c && (idle_cnt_q == TO_LAST);
  // On a tie the requester that did not hold the core last wins.
  assign winner_c   = (req0 && req1) ? ~last_q : req1;

  // Next-state logic
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    last_d     = last_q;
    idle_cnt_d = idle_cnt_q;
    gnt0_d     = gnt0_q;
    gnt1_d     = gnt1_q;
    timeout_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (req0 || req1) begin
          state_d    = ST_OWN;
          owner_d    = winner_c;
          gnt0_d     = ~winner_c;
          gnt1_d     = winner_c;
          idle_cnt_d = '0;
        end
      end

      ST_OWN: begin
        if (cyc_idle_c) begin
          idle_cnt_d = (idle_cnt_q == CNT_MAX) ? idle_cnt_q : idle_cnt_q + CNT_W'(1);
        end else begin
          idle_cnt_d = '0;
        end
        // A voluntary release takes precedence over a coincident timeout.
        if (!req_own_c) begin
          state_d = ST_DRAIN;
          gnt0_d  = 1'b0;
          gnt1_d  = 1'b0;
          last_d  = owner_q;
        end else if (to_hit_c) begin
          state_d   = ST_DRAIN;
          gnt0_d    = 1'b0;
          gnt1_d    = 1'b0;
          last_d    = owner_q;
          timeout_d = 1'b1;
        end
      end

      ST_DRAIN: begin
        if (!core_busy && !core_ack) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
        gnt0_d  = 1'b0;
        gnt1_d  = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_groestl_arbiter.sv
// Bench for groestl_arbiter: directed scenarios followed by random traffic,
// every cycle compared against a holder/drain/idle-run reference model.
module tb_groestl_arbiter;

  localparam int unsigned T = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0, req1, load0, load1, fetch0, fetch1;
  logic        gnt0, gnt1, ack0, ack1, timeout, core_load, core_fetch;
  logic [15:0] odata0, odata1;
  logic        core_busy, core_ack;
  logic [15:0] core_odata;

  int checks = 0;
  int errors = 0;

  // Reference model: who holds the core, whether it is draining, who held it last,
  // length of the current idle run, and whether a timeout pulse is due.
  int m_holder;
  bit m_drain;
  int m_last;
  int m_run;
  bit m_to;

  groestl_arbiter #(.TIMEOUT(T)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .req1(req1),
    .load0(load0), .load1(load1),
    .fetch0(fetch0), .fetch1(fetch1),
    .gnt0(gnt0), .gnt1(gnt1),
    .ack0(ack0), .ack1(ack1),
    .odata0(odata0), .odata1(odata1),
    .timeout(timeout),
    .core_load(core_load), .core_fetch(core_fetch),
    .core_busy(core_busy), .core_ack(core_ack), .core_odata(core_odata)
  );

  always #5 clk = ~clk;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0b expected=%0b t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%04h expected=%04h t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_holder = -1;
    m_drain  = 1'b0;
    m_last   = 1;
    m_run    = 0;
    m_to     = 1'b0;
  endtask

  // One clock cycle: check the combinational outputs for the present inputs,
  // advance the model across the edge, then check the registered outputs.
  task automatic step();
    bit own, idle, req_own;
    logic e_load, e_fetch;
    int n_holder, n_last, n_run;
    bit n_drain, n_to;
    #1;
    own     = (m_holder >= 0) && !m_drain;
    e_load  = own && ((m_holder == 0) ? load0 : load1);
    e_fetch = own && ((m_holder == 0) ? fetch0 : fetch1);
    chk1("core_load", core_load, e_load);
    chk1("core_fetch", core_fetch, e_fetch);
    chk1("ack0", ack0, (m_holder == 0) && core_ack);
    chk1("ack1", ack1, (m_holder == 1) && core_ack);
    chk16("odata0", odata0, (m_holder == 0) ? core_odata : 16'h0000);
    chk16("odata1", odata1, (m_holder == 1) ? core_odata : 16'h0000);

    n_holder = m_holder; n_drain = m_drain; n_last = m_last; n_run = m_run; n_to = 1'b0;
    idle = !(e_load || e_fetch || core_busy || core_ack);
    if (m_holder < 0) begin
      if (req0 || req1) begin
        if (req0 && req1) n_holder = 1 - m_last;
        else              n_holder = req0 ? 0 : 1;
        n_drain = 1'b0;
        n_run   = 0;
      end
    end else if (!m_drain) begin
      req_own = (m_holder == 0) ? req0 : req1;
      if (!req_own) begin
        n_drain = 1'b1;
        n_last  = m_holder;
      end else if ((T != 0) && idle && (m_run + 1 == int'(T))) begin
        n_drain = 1'b1;
        n_last  = m_holder;
        n_to    = 1'b1;
      end
      n_run = idle ? m_run + 1 : 0;
    end else if (!core_busy && !core_ack) begin
      n_holder = -1;
      n_drain  = 1'b0;
    end

    @(posedge clk);
    #1;
    m_holder = n_holder; m_drain = n_drain; m_last = n_last; m_run = n_run; m_to = n_to;
    chk1("gnt0", gnt0, (m_holder == 0) && !m_drain);
    chk1("gnt1", gnt1, (m_holder == 1) && !m_drain);
    chk1("timeout", timeout, m_to);
  endtask

  // Asynchronous reset pulse placed between clock edges.
  task automatic async_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    chk1("rst_gnt0", gnt0, 1'b0);
    chk1("rst_gnt1", gnt1, 1'b0);
    chk1("rst_timeout", timeout, 1'b0);
    chk1("rst_ack0", ack0, 1'b0);
    chk1("rst_ack1", ack1, 1'b0);
    chk1("rst_core_load", core_load, 1'b0);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    {req0, req1, load0, load1, fetch0, fetch1, core_busy, core_ack} = '0;
    core_odata = 16'h0000;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk1("reset_gnt0", gnt0, 1'b0);
    chk1("reset_gnt1", gnt1, 1'b0);
    chk1("reset_timeout", timeout, 1'b0);
    chk1("reset_core_fetch", core_fetch, 1'b0);
    rst_n = 1'b1;

    // Single requester grant, load pass-through, ack/odata routing
    req0 = 1'b1;
    step();
    chk1("t1_gnt0", gnt0, 1'b1);
    load0 = 1'b1;
    #1;
    chk1("t1_core_load", core_load, 1'b1);
    step();
    load0 = 1'b0; core_ack = 1'b1; core_odata = 16'hA5A5;
    #1;
    chk1("t1_ack0", ack0, 1'b1);
    chk16("t1_odata0", odata0, 16'hA5A5);
    chk1("t1_ack1", ack1, 1'b0);
    chk16("t1_odata1", odata1, 16'h0000);
    step();
    core_ack = 1'b0;
    step();

    // Simultaneous requests after reset: req0 first, req1 two cycles after release
    async_reset();
    req0 = 1'b1; req1 = 1'b1;
    step();
    chk1("t2_gnt0", gnt0, 1'b1);
    chk1("t2_gnt1_low", gnt1, 1'b0);
    req0 = 1'b0;
    step();
    chk1("t2_gnt0_fell", gnt0, 1'b0);
    step();
    chk1("t2_gnt1_wait", gnt1, 1'b0);
    step();
    chk1("t2_gnt1", gnt1, 1'b1);

    // Long busy holds off the timeout; then T idle cycles force release
    req0 = 1'b1;
    core_busy = 1'b1;
    repeat (40) step();
    chk1("t3_busy_gnt1", gnt1, 1'b1);
    chk1("t3_busy_no_to", timeout, 1'b0);
    core_busy = 1'b0;
    repeat (T - 1) step();
    chk1("t3_pre_to_gnt1", gnt1, 1'b1);
    step();
    chk1("t3_to_gnt1", gnt1, 1'b0);
    chk1("t3_to_pulse", timeout, 1'b1);
    step();
    chk1("t3_to_end", timeout, 1'b0);
    chk1("t3_gnt0_wait", gnt0, 1'b0);
    step();
    chk1("t3_gnt0", gnt0, 1'b1);

    // Release while busy: drain holds until busy clears, non-owner load blocked
    core_busy = 1'b1;
    step();
    req0 = 1'b0;
    step();
    chk1("t4_gnt0_fell", gnt0, 1'b0);
    load1 = 1'b1;
    repeat (3) begin
      #1;
      chk1("t4_drain_load", core_load, 1'b0);
      step();
      chk1("t4_drain_gnt1", gnt1, 1'b0);
    end
    load1 = 1'b0; core_busy = 1'b0;
    step();
    chk1("t4_idle_gnt1", gnt1, 1'b0);
    step();
    chk1("t4_gnt1", gnt1, 1'b1);

    // Release coincident with the timeout cycle: no pulse
    repeat (T - 1) step();
    req1 = 1'b0;
    step();
    chk1("t5_gnt1_fell", gnt1, 1'b0);
    chk1("t5_no_pulse", timeout, 1'b0);

    // Reset mid-fetch, then a lone req1 is granted immediately
    req0 = 1'b1;
    step();
    step();
    chk1("t6_gnt0", gnt0, 1'b1);
    fetch0 = 1'b1; core_ack = 1'b1; core_odata = 16'h1234;
    #1;
    chk1("t6_ack0", ack0, 1'b1);
    async_reset();
    fetch0 = 1'b0; core_ack = 1'b0; req0 = 1'b0; req1 = 1'b1;
    step();
    chk1("t6_gnt1", gnt1, 1'b1);

    // Random traffic against the model
    async_reset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(99) < 5) req0 = ~req0;
      if ($urandom_range(99) < 5) req1 = ~req1;
      load0      = ($urandom_range(99) < 8);
      load1      = ($urandom_range(99) < 8);
      fetch0     = ($urandom_range(99) < 8);
      fetch1     = ($urandom_range(99) < 8);
      core_busy  = ($urandom_range(99) < 15);
      core_ack   = ($urandom_range(99) < 10);
      core_odata = 16'($urandom);
      if ($urandom_range(499) == 0) async_reset();
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/groestl_arbiter.md
# groestl_arbiter

Two-port round-robin arbiter that shares a single Groestl core interface (load / fetch / busy / ack / 16-bit odata) between two host requesters. A requester holds the core from grant until it drops its request, so a whole load → hash → fetch sequence runs uninterrupted. An idle-timeout reclaims the core from a requester that stalls. The block sits between the host-side bus adapters and the core's interface controller.

## Interface
- TIMEOUT, 255: consecutive idle owned cycles before forced release. Range 1..255; 0 disables the timeout.
- clk  in  1  system clock
- rst_n  in  1  reset; one clock, asynchronous, active-low
- req0, req1  in  1  request / hold core (level)
- load0, load1  in  1  requester load strobe
- fetch0, fetch1  in  1  requester fetch strobe
- gnt0, gnt1  out  1  grant, registered
- ack0, ack1  out  1  routed core ack
- odata0, odata1  out  16  routed core odata
- timeout  out  1  one-cycle pulse on forced release
- core_load  out  1  to core load
- core_fetch  out  1  to core fetch
- core_busy  in  1  core busy
- core_ack  in  1  core ack
- core_odata  in  16  core output word

## Operation
- State: IDLE, OWN, DRAIN (registered). Other registers: owner (1b), last (1b), idle_cnt (8b), timeout (1b).
- Reset values: state=IDLE, owner=0, last=1 (so req0 wins the first tie), idle_cnt=0, gnt0=gnt1=0, timeout=0. All combinational outputs are 0 in IDLE.
- IDLE:
  - req0&req1 → grant !last.
  - Only one request → grant that requester.
  - No request → stay in IDLE.
  - On grant: owner←winner, gntX←1, idle_cnt←0, state←OWN.
- OWN:
  - core_load = load[owner]; core_fetch = fetch[owner]. Both are combinational.
  - Non-owner load/fetch are ignored.
  - If req[owner]==0: state←DRAIN, gnt←0, last←owner.
  - Else if the timeout condition holds (see below): state←DRAIN, gnt←0, last←owner, timeout←1 for one cycle.
- Idle counting in OWN:
  - An idle cycle is one where core_load, core_fetch, core_busy and core_ack are all 0.
  - idle_cnt increments on idle cycles, saturating at 255, and clears on any non-idle cycle.
  - Timeout condition: TIMEOUT≠0, the current cycle is idle, and idle_cnt==TIMEOUT-1.
- DRAIN:
  - core_load=core_fetch=0.
  - When ~core_busy & ~core_ack: state←IDLE.
- Routing: in OWN and DRAIN, ack[owner]=core_ack and odata[owner]=core_odata. The non-owner's ack=0 and odata=16'h0. In IDLE both are zeroed.
- Release and timeout in the same cycle counts as a normal release: no timeout pulse.
- The arbiter does not filter load issued while core_busy. The core's behaviour applies.

## Timing
- Grant latency: req sampled high in IDLE at edge N → gnt high after edge N (cycle N+1). The earliest core_load reaches the core is cycle N+1.
- Release: req low sampled at edge M → gnt low in cycle M+1, state DRAIN.
- DRAIN lasts at least 1 cycle. Earliest next grant is 2 cycles after gnt falls (DRAIN → IDLE → OWN).
- Fetch stream: ack/odata pass through combinationally with zero added latency, including while in DRAIN.
- Timeout: with TIMEOUT=T, T consecutive idle OWN cycles → gnt low and timeout high in the next cycle.
- Reset mid-operation: all registers return to reset values immediately (asynchronous). gnt drops in the same cycle. An in-flight core operation is not aborted by this block.
- Fairness: with both requesters continuously requesting, grants alternate 0,1,0,1…

## Test plan
- Reset, then req0=1 only: gnt0=1 one cycle later. Pulse load0 → core_load=1 in the same cycle. Drive core_ack with odata 16'hA5A5 → ack0=1, odata0=16'hA5A5, ack1=0, odata1=16'h0000.
- req0 and req1 rise together after reset: gnt0 first. Drop req0 → gnt0=0 next cycle. Then DRAIN, IDLE, and gnt1=1 exactly 2 cycles after gnt0 fell.
- Owner 1 holds core_busy=1 for 40 cycles, load1/fetch1=0, TIMEOUT=8: no timeout. After busy falls, 8 idle cycles → timeout pulse, gnt1=0. If req0 is high, gnt0 follows 2 cycles later.
- Owner drops req while core_busy=1: gnt falls, state stays in DRAIN until busy=0. Non-owner load during DRAIN → core_load stays 0.
- Owner drops req on the same cycle idle_cnt hits TIMEOUT-1: gnt falls, timeout stays 0.
- Assert rst_n=0 mid-fetch (ack0 active): gnt0, ack0 and timeout all 0 immediately. After release, req1=1 → gnt1 one cycle later (last=1 only forces priority on ties).
